bsg_axil_mm2s_txq: RTL and testbench

- Per-slot transmit queue placed directly downstream of the AXI-lite write decoder.
- Consumes its valid-only 32-bit word stream (txs_o/txs_v_o, one slot) and its ISR-TXC clear pulse (clr_isrs_txc_o).
- Buffers words and packs every words_per_pkt_p consecutive words into one wide packet on a valid/ready interface toward the manycore link.
- Exposes vacancy (TDFV) and the sticky ISR bits that the read side reports to the host. The top level instantiates one per FIFO slot.

---
 rtl/bsg_manycore_link_to_axil_pkg.sv | 13 +
 rtl/bsg_axil_mm2s_txq_ptr.sv | 27 ++
 rtl/bsg_axil_mm2s_txq.sv | 121 ++++++++++++
 tb/tb_bsg_axil_mm2s_txq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/bsg_manycore_link_to_axil_pkg.sv
// Shared constants for the manycore-link <-> AXI-lite bridge: bus word width,
// MM2S transmit queue geometry and ISR bit positions reported to the host.
package bsg_manycore_link_to_axil_pkg;

    localparam int axil_word_width_gp       = 32;
    localparam int axil_mm2s_txq_els_gp     = 16;
    localparam int axil_mm2s_pkt_words_gp   = 4;

    // ISR layout: transmit-complete sits below the transmit-overrun flag
    localparam int axil_mm2s_isr_txc_bit_gp = 27;
    localparam int axil_mm2s_isr_ovf_bit_gp = 28;

endpackage

// File: rtl/bsg_axil_mm2s_txq_ptr.sv
// Wrapping circular-buffer pointer with enable and a fixed increment.
// The queue depth is a power of two, so wrap is natural truncation.
module bsg_axil_mm2s_txq_ptr
    import bsg_manycore_link_to_axil_pkg::*;
#(
    parameter int els_p   = axil_mm2s_txq_els_gp,
    parameter int inc_p   = 1,
    parameter int ptr_w_p = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               en_i,
    output logic [ptr_w_p-1:0] ptr_o
);

    // An increment equal to the depth leaves the pointer where it is
    localparam logic [ptr_w_p-1:0] inc_lp = ptr_w_p'(inc_p % els_p);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_o <= '0;
        end else if (en_i) begin
            ptr_o <= ptr_o + inc_lp;
        end
    end

endmodule

// File: rtl/bsg_axil_mm2s_txq.sv
// Per-slot MM2S transmit queue: buffers AXI-lite write words and emits them
// packed words_per_pkt_p at a time. Optional BSG_AXIL_MM2S_TXQ_PKT_CNT_EN adds pkt_cnt_o.
module bsg_axil_mm2s_txq
    import bsg_manycore_link_to_axil_pkg::*;
#(
    parameter int els_p           = axil_mm2s_txq_els_gp,
    parameter int words_per_pkt_p = axil_mm2s_pkt_words_gp
) (
    input  logic                                          clk_i,
    input  logic                                          reset_n_i,
    input  logic [axil_word_width_gp-1:0]                 tx_i,
    input  logic                                          tx_v_i,
    input  logic                                          clr_txc_i,
    input  logic                                          clr_ovf_i,
    output logic [axil_word_width_gp*words_per_pkt_p-1:0] pkt_o,
    output logic                                          pkt_v_o,
    input  logic                                          pkt_ready_i,
    output logic [$clog2(els_p+1)-1:0]                    vacancy_o,
`ifdef BSG_AXIL_MM2S_TXQ_PKT_CNT_EN
    output logic [31:0]                                   pkt_cnt_o,
`endif
    output logic                                          isr_txc_o,
    output logic                                          isr_ovf_o
);

    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    localparam logic [cnt_w_lp-1:0] els_lp = cnt_w_lp'(els_p);
    localparam logic [cnt_w_lp-1:0] wpp_lp = cnt_w_lp'(words_per_pkt_p);

    logic [axil_word_width_gp-1:0] mem_r [els_p];
    logic [ptr_w_lp-1:0]           wptr_r;
    logic [ptr_w_lp-1:0]           rptr_r;
    logic [cnt_w_lp-1:0]           count_r;
    logic [cnt_w_lp-1:0]           count_n;
    logic                          full;
    logic                          wr_acc;
    logic                          wr_drop;
    logic                          pop;
    logic                          txc_r;
    logic                          ovf_r;

    // Acceptance looks only at the registered count, never at a same-cycle pop
    assign full    = (count_r == els_lp);
    assign wr_acc  = tx_v_i & ~full;
    assign wr_drop = tx_v_i & full;
    assign pkt_v_o = (count_r >= wpp_lp);
    assign pop     = pkt_v_o & pkt_ready_i;

    assign count_n   = count_r + cnt_w_lp'(wr_acc) - (pop ? wpp_lp : '0);
    assign vacancy_o = els_lp - count_r;
    assign isr_txc_o = txc_r;
    assign isr_ovf_o = ovf_r;

    bsg_axil_mm2s_txq_ptr #(
        .els_p   (els_p),
        .inc_p   (1),
        .ptr_w_p (ptr_w_lp)
    ) wptr (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .en_i      (wr_acc),
        .ptr_o     (wptr_r)
    );

    bsg_axil_mm2s_txq_ptr #(
        .els_p   (els_p),
        .inc_p   (words_per_pkt_p),
        .ptr_w_p (ptr_w_lp)
    ) rptr (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .en_i      (pop),
        .ptr_o     (rptr_r)
    );

    // Storage holds data only and is deliberately left unreset
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem_r[wptr_r] <= tx_i;
        end
    end

    // rptr stays packet-aligned, so these indices never straddle the wrap
    for (genvar k = 0; k < words_per_pkt_p; k++) begin : g_word
        assign pkt_o[axil_word_width_gp*k +: axil_word_width_gp] = mem_r[rptr_r + ptr_w_lp'(k)];
    end

    // Sticky flags: a set in the same cycle as its clear wins
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_r <= '0;
            txc_r   <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            count_r <= count_n;
            if (pop) begin
                txc_r <= 1'b1;
            end else if (clr_txc_i) begin
                txc_r <= 1'b0;
            end
            if (wr_drop) begin
                ovf_r <= 1'b1;
            end else if (clr_ovf_i) begin
                ovf_r <= 1'b0;
            end
        end
    end

`ifdef BSG_AXIL_MM2S_TXQ_PKT_CNT_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pkt_cnt_o <= '0;
        end else if (pop) begin
            pkt_cnt_o <= pkt_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bsg_axil_mm2s_txq.sv
// Self-checking bench for bsg_axil_mm2s_txq (els_p=16, words_per_pkt_p=4):
// queue-based reference model compared every cycle plus literal spot checks.
module tb_bsg_axil_mm2s_txq;

    localparam int ELS = 16;
    localparam int WPP = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [31:0]       tx = '0;
    logic              tx_v = 1'b0;
    logic              clr_txc = 1'b0;
    logic              clr_ovf = 1'b0;
    logic              rdy = 1'b0;
    logic [32*WPP-1:0] pkt;
    logic              pkt_v;
    logic [4:0]        vacancy;
    logic              isr_txc;
    logic              isr_ovf;
`ifdef BSG_AXIL_MM2S_TXQ_PKT_CNT_EN
    logic [31:0]       pkt_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state
    int unsigned m_q[$];
    bit          m_txc = 1'b0;
    bit          m_ovf = 1'b0;
    int unsigned m_pkts = 0;

    always #5 clk = ~clk;

    bsg_axil_mm2s_txq #(.els_p(ELS), .words_per_pkt_p(WPP)) dut (
        .clk_i       (clk),
        .reset_n_i   (rst_n),
        .tx_i        (tx),
        .tx_v_i      (tx_v),
        .clr_txc_i   (clr_txc),
        .clr_ovf_i   (clr_ovf),
        .pkt_o       (pkt),
        .pkt_v_o     (pkt_v),
        .pkt_ready_i (rdy),
        .vacancy_o   (vacancy),
`ifdef BSG_AXIL_MM2S_TXQ_PKT_CNT_EN
        .pkt_cnt_o   (pkt_cnt),
`endif
        .isr_txc_o   (isr_txc),
        .isr_ovf_o   (isr_ovf)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a word queue; a packet leaves when 4 words are present and ready is high
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_txc = 1'b0;
            m_ovf = 1'b0;
            m_pkts = 0;
        end else begin
            bit was_full;
            bit popping;
            was_full = (m_q.size() == ELS);
            popping  = (m_q.size() >= WPP) && rdy;
            if (popping) begin
                for (int i = 0; i < WPP; i++) void'(m_q.pop_front());
                m_txc = 1'b1;
                m_pkts++;
            end else if (clr_txc) begin
                m_txc = 1'b0;
            end
            if (tx_v && was_full) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            if (tx_v && !was_full) m_q.push_back(tx);
        end
    end

    always @(negedge clk) begin
        logic [127:0] exp_pkt;
        check("pkt_v", 128'(pkt_v), 128'(m_q.size() >= WPP));
        check("vacancy", 128'(vacancy), 128'(ELS - m_q.size()));
        check("isr_txc", 128'(isr_txc), 128'(m_txc));
        check("isr_ovf", 128'(isr_ovf), 128'(m_ovf));
`ifdef BSG_AXIL_MM2S_TXQ_PKT_CNT_EN
        check("pkt_cnt", 128'(pkt_cnt), 128'(m_pkts));
`endif
        if (m_q.size() >= WPP) begin
            exp_pkt = '0;
            for (int k = 0; k < WPP; k++) exp_pkt[32*k +: 32] = m_q[k];
            check("pkt_o", 128'(pkt), exp_pkt);
        end
    end

    // One clock: apply inputs, take the edge, then return strobes to idle
    task automatic step(input logic v, input logic [31:0] d, input logic ctxc, input logic covf);
        tx_v = v;
        tx = d;
        clr_txc = ctxc;
        clr_ovf = covf;
        @(posedge clk);
        #1;
        tx_v = 1'b0;
        clr_txc = 1'b0;
        clr_ovf = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pkt_v", 128'(pkt_v), 128'd0);
        check("rst_vacancy", 128'(vacancy), 128'd16);
        check("rst_isr", 128'({isr_txc, isr_ovf}), 128'd0);
        rst_n = 1'b1;

        // Packing of the first four words and a single pop
        rdy = 1'b1;
        step(1'b1, 32'h11, 1'b0, 1'b0);
        step(1'b1, 32'h22, 1'b0, 1'b0);
        step(1'b1, 32'h33, 1'b0, 1'b0);
        check("t1_pkt_v_low", 128'(pkt_v), 128'd0);
        check("t1_vacancy13", 128'(vacancy), 128'd13);
        step(1'b1, 32'h44, 1'b0, 1'b0);
        check("t1_pkt_v_high", 128'(pkt_v), 128'd1);
        check("t1_pkt", 128'(pkt), 128'h00000044_00000033_00000022_00000011);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        check("t1_txc", 128'(isr_txc), 128'd1);
        check("t1_vacancy16", 128'(vacancy), 128'd16);

        // Fill to capacity with backpressure, then overrun
        rdy = 1'b0;
        for (int i = 0; i < 16; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        check("t2_vacancy0", 128'(vacancy), 128'd0);
        step(1'b1, 32'd16, 1'b0, 1'b0);
        check("t2_ovf", 128'(isr_ovf), 128'd1);
        check("t2_head", 128'(pkt), 128'h00000003_00000002_00000001_00000000);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check("t2_ovf_clr", 128'(isr_ovf), 128'd0);

        // Simultaneous write and pop at count 15
        rdy = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b0);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
        check("t3_vacancy1", 128'(vacancy), 128'd1);
        rdy = 1'b1;
        step(1'b1, 32'hA3, 1'b0, 1'b0);
        rdy = 1'b0;
        check("t3_vacancy4", 128'(vacancy), 128'd4);

        // Drain across the wrapped region, then refill and drain again
        rdy = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        rdy = 1'b0;
        check("t4_wrap_head", 128'(pkt), 128'h000000A3_000000A2_000000A1_000000A0);
        for (int i = 0; i < 12; i++) step(1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0);
        rdy = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
        rdy = 1'b0;
        check("t4_empty", 128'(vacancy), 128'd16);

        // Set beats clear on isr_txc
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check("t5_txc_clr", 128'(isr_txc), 128'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 32'hD0 + 32'(i), 1'b0, 1'b0);
        rdy = 1'b1;
        step(1'b0, 32'h0, 1'b1, 1'b0);
        rdy = 1'b0;
        check("t5_txc_set_wins", 128'(isr_txc), 128'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check("t5_txc_clr2", 128'(isr_txc), 128'd0);

        // Asynchronous reset with a partial second packet queued
        for (int i = 0; i < 6; i++) step(1'b1, 32'hE0 + 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'h0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_pkt_v", 128'(pkt_v), 128'd0);
        check("t6_rst_vacancy", 128'(vacancy), 128'd16);
        check("t6_rst_isr", 128'({isr_txc, isr_ovf}), 128'd0);
`ifdef BSG_AXIL_MM2S_TXQ_PKT_CNT_EN
        check("t6_rst_pkt_cnt", 128'(pkt_cnt), 128'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 32'hB0 + 32'(i), 1'b0, 1'b0);
        check("t6_fresh_head", 128'(pkt), 128'h000000B3_000000B2_000000B1_000000B0);

        // Three pops after reset
        for (int i = 0; i < 8; i++) step(1'b1, 32'hF0 + 32'(i), 1'b0, 1'b0);
        rdy = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
        rdy = 1'b0;
        check("t7_vacancy", 128'(vacancy), 128'd16);
`ifdef BSG_AXIL_MM2S_TXQ_PKT_CNT_EN
        check("t7_pkt_cnt", 128'(pkt_cnt), 128'd3);
`endif
        step(1'b0, 32'h0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
